// File: rtl/ret_stack_if.sv
// ret_stack_if: EX-stage view of the return-address stack.
//   master: pipeline side, drives ex_instr/pc/stall/clr, observes the stack.
//   slave : ret_stack side, consumes the EX controls, produces ret_pc,
//           ret_valid, full, count and the sticky overflow/underflow flags.
interface ret_stack_if #(
  parameter int CNT_W = 4
);
  logic [15:0]      ex_instr;
  logic [15:0]      pc;
  logic             stall;
  logic             clr;
  logic [15:0]      ret_pc;
  logic             ret_valid;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;

  modport master (
    output ex_instr, pc, stall, clr,
    input  ret_pc, ret_valid, full, count, overflow, underflow
  );

  modport slave (
    input  ex_instr, pc, stall, clr,
    output ret_pc, ret_valid, full, count, overflow, underflow
  );
endinterface

// File: rtl/ret_stack.sv
// ret_stack: circular return-address stack feeding RET targets to fetch.
//   clk, rst : clock, asynchronous active-high reset
//   rs       : ret_stack_if.slave
//     ex_instr/pc/stall/clr in  -> CALL pushes pc+1, RET pops
//     ret_pc/ret_valid      out -> top entry (zero when empty), same-cycle read
//     full/count            out -> occupancy
//     overflow/underflow    out -> sticky error flags, cleared only by rst
// OP_CALL/OP_RET carry the CALL/RET opcode encodings of the core.
module ret_stack #(
  parameter int         DEPTH   = 8,   // power of 2, >= 2
  parameter int         PTR_W   = $clog2(DEPTH),
  parameter int         CNT_W   = $clog2(DEPTH) + 1,
  parameter logic [3:0] OP_CALL = 4'hC,
  parameter logic [3:0] OP_RET  = 4'hD
) (
  input logic        clk,
  input logic        rst,
  ret_stack_if.slave rs
);

  logic [DEPTH-1:0][15:0] mem;
  logic [PTR_W-1:0]       top;     // next free slot
  logic [PTR_W-1:0]       top_m1;  // current top entry
  logic [CNT_W-1:0]       cnt;
  logic                   ovf, unf;
  logic                   empty, is_full, do_push, do_pop;
  logic                   unused_instr;

  // Only the opcode field matters here.
  assign unused_instr = ^rs.ex_instr[11:0];

  always_comb begin
    // PTR_W-bit arithmetic gives the mod-DEPTH wrap for free.
    top_m1  = top - PTR_W'(1);
    empty   = (cnt == '0);
    is_full = (cnt == CNT_W'(DEPTH));
    do_push = (rs.ex_instr[15:12] == OP_CALL) && !rs.stall && !rs.clr;
    do_pop  = (rs.ex_instr[15:12] == OP_RET)  && !rs.stall && !rs.clr;
  end

  // clr is a flush (context switch / exception) and is honoured even while
  // EX is stalled; stall only gates CALL/RET.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      mem <= '0;
    end else if (rs.clr) begin
      top <= '0;
      cnt <= '0;
    end else if (do_push) begin
      // When full the write lands on the oldest entry, keeping the newest
      // DEPTH return addresses in LIFO order.
      mem[top] <= rs.pc + 16'd1;
      top      <= top + PTR_W'(1);
      if (is_full) ovf <= 1'b1;
      else         cnt <= cnt + CNT_W'(1);
    end else if (do_pop) begin
      if (empty) begin
        unf <= 1'b1;
      end else begin
        top <= top_m1;
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign rs.ret_pc    = empty ? 16'h0000 : mem[top_m1];
  assign rs.ret_valid = !empty;
  assign rs.full      = is_full;
  assign rs.count     = cnt;
  assign rs.overflow  = ovf;
  assign rs.underflow = unf;

endmodule

// File: tb/tb_ret_stack.sv
module tb_ret_stack;
  localparam int         DEPTH   = 8;
  localparam int         CNT_W   = 4;
  localparam logic [3:0] OP_CALL = 4'hC;
  localparam logic [3:0] OP_RET  = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'h0;

  logic clk = 1'b0;
  logic rst;

  ret_stack_if #(.CNT_W(CNT_W)) bus();

  ret_stack #(
    .DEPTH(DEPTH), .PTR_W(3), .CNT_W(CNT_W),
    .OP_CALL(OP_CALL), .OP_RET(OP_RET)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rs (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: return addresses pushed on CALL, popped from the back on RET.
  logic [15:0] sb[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  task automatic drive(input logic [3:0] op, input logic [15:0] p,
                       input logic st, input logic cl);
    bus.ex_instr = {op, 12'h5A5};
    bus.pc       = p;
    bus.stall    = st;
    bus.clr      = cl;
  endtask

  // One EX cycle: inputs applied just after an edge, outputs sampled
  // mid-cycle, then the edge that commits the operation.
  task automatic step(input logic [3:0] op, input logic [15:0] p,
                      input logic st, input logic cl,
                      output logic [15:0] seen_pc, output logic seen_vld);
    drive(op, p, st, cl);
    #1;
    seen_pc  = bus.ret_pc;
    seen_vld = bus.ret_valid;
    @(posedge clk); #1;
    drive(OP_NOP, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic do_call(input logic [15:0] p, input logic st, input logic cl);
    logic [15:0] sp; logic sv;
    step(OP_CALL, p, st, cl, sp, sv);
    if (cl) sb.delete();
    else if (!st) begin
      if (sb.size() == DEPTH) begin
        void'(sb.pop_front());
        m_ovf = 1'b1;
      end
      sb.push_back(p + 16'd1);
    end
  endtask

  task automatic do_ret(input logic st, input logic cl,
                        output logic [15:0] exp_pc, output logic exp_vld,
                        output logic [15:0] seen_pc, output logic seen_vld);
    exp_vld = (sb.size() > 0);
    exp_pc  = exp_vld ? sb[$] : 16'h0000;
    step(OP_RET, 16'h7777, st, cl, seen_pc, seen_vld);
    if (cl) sb.delete();
    else if (!st) begin
      if (exp_vld) void'(sb.pop_back());
      else         m_unf = 1'b1;
    end
  endtask

  task automatic test_reset;
    checks++;
    if (bus.count !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    checks++;
    if (bus.ret_valid !== 1'b0 || bus.ret_pc !== 16'h0000) begin
      failures++; $display("FAIL reset_ret: got vld=%b pc=%h expected vld=0 pc=0000", bus.ret_valid, bus.ret_pc);
    end
    checks++;
    if (bus.full !== 1'b0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got full=%b ovf=%b unf=%b expected 0 0 0", bus.full, bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_basic;
    logic [15:0] ep, sp; logic ev, sv;
    do_call(16'h0120, 1'b0, 1'b0);
    checks++;
    if (bus.ret_pc !== 16'h0121 || bus.count !== CNT_W'(sb.size())) begin
      failures++; $display("FAIL basic_push: got pc=%h cnt=%0d expected pc=0121 cnt=%0d", bus.ret_pc, bus.count, sb.size());
    end
    do_ret(1'b0, 1'b0, ep, ev, sp, sv);
    checks++;
    if (sp !== ep || sp !== 16'h0121 || sv !== 1'b1) begin
      failures++; $display("FAIL basic_pop: got pc=%h vld=%b expected pc=%h vld=1", sp, sv, ep);
    end
    checks++;
    if (bus.count !== 4'd0 || bus.ret_valid !== 1'b0) begin
      failures++; $display("FAIL basic_after_pop: got cnt=%0d vld=%b expected 0 0", bus.count, bus.ret_valid);
    end
  endtask

  task automatic test_nesting;
    logic [15:0] calls [3] = '{16'h0010, 16'h0200, 16'h0FFF};
    logic [15:0] rets  [3] = '{16'h1000, 16'h0201, 16'h0011};
    logic [15:0] ep, sp; logic ev, sv;
    for (int i = 0; i < 3; i++) begin
      do_call(calls[i], 1'b0, 1'b0);
      checks++;
      if (bus.ret_pc !== calls[i] + 16'd1) begin
        failures++; $display("FAIL nest_push%0d: got %h expected %h", i, bus.ret_pc, calls[i] + 16'd1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      do_ret(1'b0, 1'b0, ep, ev, sp, sv);
      checks++;
      if (sp !== ep || sp !== rets[i]) begin
        failures++; $display("FAIL nest_pop%0d: got %h expected %h", i, sp, rets[i]);
      end
    end
  endtask

  task automatic test_pc_wrap;
    logic [15:0] ep, sp; logic ev, sv;
    do_call(16'hFFFF, 1'b0, 1'b0);
    checks++;
    if (bus.ret_pc !== 16'h0000 || bus.ret_valid !== 1'b1) begin
      failures++; $display("FAIL pc_wrap: got pc=%h vld=%b expected pc=0000 vld=1", bus.ret_pc, bus.ret_valid);
    end
    do_ret(1'b0, 1'b0, ep, ev, sp, sv);
    checks++;
    if (sp !== ep || sv !== ev || bus.count !== 4'd0) begin
      failures++; $display("FAIL pc_wrap_pop: got pc=%h vld=%b cnt=%0d expected pc=%h vld=%b cnt=0", sp, sv, bus.count, ep, ev);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] ep, sp; logic ev, sv;
    for (int i = 0; i < 9; i++) do_call(16'h0100 + 16'(i), 1'b0, 1'b0);
    checks++;
    if (bus.full !== 1'b1 || bus.count !== 4'd8 || bus.overflow !== m_ovf || bus.ret_pc !== 16'h0109) begin
      failures++; $display("FAIL ovf_state: got full=%b cnt=%0d ovf=%b pc=%h expected 1 8 %b 0109",
                           bus.full, bus.count, bus.overflow, bus.ret_pc, m_ovf);
    end
    for (int i = 0; i < 8; i++) begin
      do_ret(1'b0, 1'b0, ep, ev, sp, sv);
      checks++;
      if (sp !== ep || sp !== 16'h0109 - 16'(i)) begin
        failures++; $display("FAIL ovf_pop%0d: got %h expected %h", i, sp, 16'h0109 - 16'(i));
      end
    end
    do_ret(1'b0, 1'b0, ep, ev, sp, sv);
    checks++;
    if (sv !== 1'b0 || sp !== 16'h0000) begin
      failures++; $display("FAIL unf_ret: got pc=%h vld=%b expected 0000 0", sp, sv);
    end
    checks++;
    if (bus.underflow !== m_unf || bus.count !== 4'd0 || bus.overflow !== 1'b1) begin
      failures++; $display("FAIL unf_flags: got unf=%b cnt=%0d ovf=%b expected %b 0 1", bus.underflow, bus.count, bus.overflow, m_unf);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) do_call(16'h0A00 + 16'(i), 1'b0, 1'b0);
    checks++;
    if (bus.count !== CNT_W'(sb.size())) begin
      failures++; $display("FAIL mid_pre: got cnt=%0d expected %0d", bus.count, sb.size());
    end
    // Reset lands mid-cycle with a CALL in EX; the CALL must be discarded.
    drive(OP_CALL, 16'h0B00, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    sb.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    checks++;
    if (bus.count !== 4'd0 || bus.ret_valid !== 1'b0 || bus.ret_pc !== 16'h0000) begin
      failures++; $display("FAIL mid_reset: got cnt=%0d vld=%b pc=%h expected 0 0 0000", bus.count, bus.ret_valid, bus.ret_pc);
    end
    checks++;
    if (bus.overflow !== m_ovf || bus.underflow !== m_unf) begin
      failures++; $display("FAIL mid_reset_flags: got ovf=%b unf=%b expected 0 0", bus.overflow, bus.underflow);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(OP_NOP, 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (bus.count !== 4'd0) begin
      failures++; $display("FAIL mid_discard: got cnt=%0d expected 0", bus.count);
    end
  endtask

  task automatic test_stall_clr;
    logic [15:0] ep, sp; logic ev, sv;
    do_call(16'h0300, 1'b1, 1'b0);
    checks++;
    if (bus.count !== CNT_W'(sb.size()) || bus.ret_valid !== 1'b0) begin
      failures++; $display("FAIL stall_call: got cnt=%0d vld=%b expected 0 0", bus.count, bus.ret_valid);
    end
    do_call(16'h0400, 1'b0, 1'b0);
    do_call(16'h0500, 1'b0, 1'b0);
    do_ret(1'b1, 1'b0, ep, ev, sp, sv);
    checks++;
    if (sp !== ep || sp !== 16'h0501 || bus.count !== 4'd2) begin
      failures++; $display("FAIL stall_ret: got pc=%h cnt=%0d expected 0501 2", sp, bus.count);
    end
    do_ret(1'b0, 1'b1, ep, ev, sp, sv);
    checks++;
    if (bus.count !== CNT_W'(sb.size()) || bus.underflow !== 1'b0 || bus.ret_valid !== 1'b0) begin
      failures++; $display("FAIL clr_ret: got cnt=%0d unf=%b vld=%b expected 0 0 0", bus.count, bus.underflow, bus.ret_valid);
    end
    do_call(16'h0600, 1'b0, 1'b0);
    checks++;
    if (bus.ret_pc !== 16'h0601 || bus.count !== CNT_W'(sb.size())) begin
      failures++; $display("FAIL post_clr_push: got pc=%h cnt=%0d expected 0601 %0d", bus.ret_pc, bus.count, sb.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(OP_NOP, 16'h0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_nesting();
    test_pc_wrap();
    test_overflow();
    test_reset_mid();
    test_stall_clr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
